exception_ctrl: RTL

Exception sequencer for the single-cycle LEGv8 core. It detects exception sources (invalid opcode, ERET outside a handler, an optional external interrupt) and flushes the offending instruction. It redirects the PC to the handler vector, holds ELR/ESR for MRS reads, and sequences the ERET return. It sits beside the main decoder and ALU control decoder and drives the PC-source and write-suppress controls of the datapath.

---
 rtl/exception_ctrl_if.sv | 31 +++
 rtl/exception_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl_if.sv
// Signal bundle between the LEGv8 datapath/decoders and the exception sequencer.
// master = datapath side, slave = exception_ctrl.
interface exception_ctrl_if #(
   parameter int N = 64
);
   logic [N-1:0] pc_in;
   logic         invalid_op;
   logic         eret;
   logic         ext_irq;
   logic         sys_sel;
   logic         flush;
   logic         exc_pc_sel;
   logic         eret_pc_sel;
   logic [N-1:0] exc_vector;
   logic         in_handler;
   logic         halt;
   logic [N-1:0] sys_rdata;
   logic         irq_pending;

   modport master (
      output pc_in, invalid_op, eret, ext_irq, sys_sel,
      input  flush, exc_pc_sel, eret_pc_sel, exc_vector, in_handler, halt,
             sys_rdata, irq_pending
   );

   modport slave (
      input  pc_in, invalid_op, eret, ext_irq, sys_sel,
      output flush, exc_pc_sel, eret_pc_sel, exc_vector, in_handler, halt,
             sys_rdata, irq_pending
   );
endinterface

// File: rtl/exception_ctrl.sv
// Exception sequencer for the single-cycle LEGv8 core: entry, ERET return, double-fault halt.
// Define EXC_IRQ_EN to include the external interrupt synchronizer and pending latch.
module exception_ctrl #(
   parameter int           N           = 64,
   parameter logic [N-1:0] VECTOR_ADDR = N'(64'hD8)
) (
   input logic             clk,
   input logic             reset,
   exception_ctrl_if.slave bus
);
   localparam logic [3:0] CAUSE_INV = 4'b0001;
   localparam logic [3:0] CAUSE_IRQ = 4'b0010;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HANDLER = 2'd1,
      ST_HALTED  = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [N-1:0] r_elr;
   logic [3:0]   r_esr;
   logic         w_sync_exc;
   logic         w_irq_pend;
   logic         w_enter;
   logic [3:0]   w_cause;
   logic         w_flush;
   logic         w_exc_sel;
   logic         w_eret_sel;
   logic         w_in_handler;
   logic         w_halt;

   // ERET outside a handler is treated exactly like an unrecognised opcode
   assign w_sync_exc = bus.invalid_op | bus.eret;

`ifdef EXC_IRQ_EN
   logic r_sync1;
   logic r_sync2;
   logic r_sync3;
   logic r_irq_pending;
   logic w_irq_edge;
   logic w_take_irq;

   // Two-flop synchronizer plus one history flop for rising-edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= bus.ext_irq;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_irq_edge = r_sync2 & ~r_sync3;
   assign w_take_irq = (r_state == ST_IDLE) & ~w_sync_exc & r_irq_pending;

   // Pending latch: a fresh edge wins over the clear of the entry being taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq_pending <= 1'b0;
      end else if (w_irq_edge) begin
         r_irq_pending <= 1'b1;
      end else if (w_take_irq) begin
         r_irq_pending <= 1'b0;
      end else begin
         r_irq_pending <= r_irq_pending;
      end
   end

   assign w_irq_pend = r_irq_pending;
`else
   logic w_ext_irq_unused;

   assign w_ext_irq_unused = bus.ext_irq;
   assign w_irq_pend       = 1'b0;
`endif

   // Next-state and datapath controls; all redirects are combinational
   always_comb begin
      w_state_nxt  = r_state;
      w_flush      = 1'b0;
      w_exc_sel    = 1'b0;
      w_eret_sel   = 1'b0;
      w_in_handler = 1'b0;
      w_halt       = 1'b0;
      w_enter      = 1'b0;
      w_cause      = CAUSE_INV;
      case (r_state)
         ST_IDLE: begin
            if (w_sync_exc | w_irq_pend) begin
               w_flush     = 1'b1;
               w_exc_sel   = 1'b1;
               w_enter     = 1'b1;
               w_cause     = w_sync_exc ? CAUSE_INV : CAUSE_IRQ;
               w_state_nxt = ST_HANDLER;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_HANDLER: begin
            w_in_handler = 1'b1;
            if (bus.invalid_op) begin
               w_flush     = 1'b1;
               w_halt      = 1'b1;
               w_state_nxt = ST_HALTED;
            end else if (bus.eret) begin
               w_eret_sel  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_HANDLER;
            end
         end
         ST_HALTED: begin
            w_flush     = 1'b1;
            w_halt      = 1'b1;
            w_state_nxt = ST_HALTED;
         end
         default: begin
            w_flush     = 1'b1;
            w_halt      = 1'b1;
            w_state_nxt = ST_HALTED;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ELR/ESR capture on exception entry only; a double fault leaves them intact
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_elr <= {N{1'b0}};
         r_esr <= 4'b0000;
      end else if (w_enter) begin
         r_elr <= bus.pc_in;
         r_esr <= w_cause;
      end else begin
         r_elr <= r_elr;
         r_esr <= r_esr;
      end
   end

   assign bus.flush       = w_flush;
   assign bus.exc_pc_sel  = w_exc_sel;
   assign bus.eret_pc_sel = w_eret_sel;
   assign bus.exc_vector  = VECTOR_ADDR;
   assign bus.in_handler  = w_in_handler;
   assign bus.halt        = w_halt;
   assign bus.irq_pending = w_irq_pend;
   assign bus.sys_rdata   = bus.sys_sel ? {{(N-4){1'b0}}, r_esr} : r_elr;
endmodule
